// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the bit-serial add/subtract unit.
// The master is the issuing pipeline stage and the slave is serial_adder_ctrl.
interface serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start_valid, op, a_in, b_in,
        input  start_ready, result, cout, ovf, zero, busy, done
    );

    modport slave (
        input  start_valid, op, a_in, b_in,
        output start_ready, result, cout, ovf, zero, busy, done
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit. One full-adder slice is used once per clock,
// LSB first, for WIDTH cycles. SUB is done as a + ~b + 1: B is inverted at
// capture and the carry flop is preset to 1.

// Single-bit full adder slice.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] r_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    logic             accept;
    logic             step;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_co;
    logic [WIDTH-1:0] r_sh_next;

    serial_adder_fa u_fa (
        .a  (a_sh_reg[0]),
        .b  (b_sh_reg[0]),
        .ci (carry_reg),
        .s  (fa_sum),
        .co (fa_co)
    );

    // Sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
    assign r_sh_next = {fa_sum, r_sh_reg[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        last_bit   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    last_bit   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting and the result/flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            r_sh_reg   <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= bus.a_in;
            b_sh_reg  <= bus.op ? ~bus.b_in : bus.b_in;
            carry_reg <= bus.op;
            cnt_reg   <= '0;
        end else if (step) begin
            a_sh_reg  <= a_sh_reg >> 1;
            b_sh_reg  <= b_sh_reg >> 1;
            r_sh_reg  <= r_sh_next;
            carry_reg <= fa_co;
            cnt_reg   <= cnt_reg + 1'b1;
            if (last_bit) begin
                // carry_reg here is the carry into the MSB.
                result_reg <= r_sh_next;
                cout_reg   <= fa_co;
                ovf_reg    <= carry_reg ^ fa_co;
                zero_reg   <= (r_sh_next == '0);
            end
        end
    end

    assign bus.start_ready = (state_reg == ST_IDLE);
    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.done        = (state_reg == ST_DONE);
    assign bus.result      = result_reg;
    assign bus.cout        = cout_reg;
    assign bus.ovf         = ovf_reg;
    assign bus.zero        = zero_reg;
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Multi-cycle bit-serial add/subtract unit for the processor's low-area ALU option.
- Drives a single 1-bit full-adder slice (instantiated internally) once per clock, LSB first, over WIDTH cycles.
- Handles operand capture, carry sequencing, flag generation and the start/done handshake with the issuing pipeline stage.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start_valid  in  1  request to begin an operation.
- start_ready  out  1  high only in IDLE; a request is accepted when start_valid and start_ready are both high at a clk edge.
- op  in  1  0 = ADD, 1 = SUB (a − b); sampled on accept.
- a_in  in  WIDTH  operand A; sampled on accept.
- b_in  in  WIDTH  operand B; sampled on accept.
- result  out  WIDTH  registered result, held until the next completion.
- cout  out  1  final carry-out (for SUB: 1 = no borrow, a ≥ b unsigned).
- ovf  out  1  signed overflow.
- zero  out  1  result == 0.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst low, async):
  - State = IDLE.
  - result = 0, cout = 0, ovf = 0, zero = 0, done = 0, busy = 0.
  - Internal shift registers, carry FF and counter are cleared.
  - start_ready = 1 (derived from state).
- States: IDLE, RUN, DONE.
- IDLE:
  - On accept: A_sh ← a_in; B_sh ← b_in when op = 0, or ~b_in when op = 1.
  - Carry FF ← op (injects +1 for two's-complement subtract).
  - cnt ← 0; go to RUN.
  - No accept: stay in IDLE.
- RUN, one bit per cycle:
  - Full-adder inputs are A_sh[0], B_sh[0] and the carry FF.
  - R_sh shifts right, with the sum bit entering at bit WIDTH−1.
  - A_sh and B_sh shift right by one.
  - Carry FF ← adder carry-out; cnt ← cnt + 1.
  - When cnt == WIDTH−1 (last bit):
    - Capture carry-in of the MSB as c_msb.
    - Load output registers: result ← final R_sh value (including this cycle's sum bit), cout ← adder carry-out, ovf ← c_msb XOR carry-out, zero ← (final result == 0).
    - Go to DONE.
  - The counter is $clog2(WIDTH) bits and never wraps inside an operation.
- DONE:
  - done = 1 for exactly this cycle, then return to IDLE.
  - start_ready = 0 during DONE.
- Latency and throughput:
  - Request accepted at edge k; result, flags and done are visible after edge k+WIDTH; done is high during cycle k+WIDTH.
  - The next accept occurs no earlier than edge k+WIDTH+2.
- Inputs while busy:
  - start_valid during RUN/DONE is ignored (ready low); the request must be held until accepted.
  - a_in, b_in and op changes after accept do not affect the operation in flight.
- Outputs between operations:
  - result and flags change only on the last-bit cycle and otherwise hold their previous values, including through IDLE.
  - done and busy are registered or state-decoded, glitch-free.
- Reset mid-operation aborts immediately:
  - No done pulse; all outputs return to reset values.
  - First accept is possible on the first edge after rst deasserts.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - ovf follows the two's-complement rule: operands of the same sign (after B inversion) producing a result of the opposite sign.

Test Plan:
- WIDTH=32, ADD 0x00000005 + 0x00000003 → result 0x00000008, cout 0, ovf 0, zero 0; done exactly 32 cycles after accept edge, busy high 33 cycles.
- ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, ovf 1, cout 0. ADD 0xFFFFFFFF + 0x00000001 → 0x00000000, cout 1, zero 1, ovf 0.
- SUB 5 − 5 → 0, zero 1, cout 1. SUB 3 − 5 → 0xFFFFFFFE, cout 0, ovf 0. SUB 0x80000000 − 1 → 0x7FFFFFFF, ovf 1.
- start_valid held high with operands changing every cycle:
  - Accepts occur only every 34 cycles, when start_ready is high.
  - Each result matches the operands present at its accept edge.
  - result is stable between done pulses.
- Assert rst low during RUN cycle 10 of an ADD:
  - All outputs go to 0 asynchronously; start_ready = 1; no done.
  - After release, ADD 0x12345678 + 0x11111111 → 0x23456789.
- WIDTH=4:
  - Exhaustive sweep of all 256 operand pairs × both ops, checked against a behavioural model for result/cout/ovf/zero.
  - Latency of 4 cycles and done pulse width of 1 checked on every operation.
